bypass_hazard_unit: RTL and testbench
=====================================

BYPASS_HAZARD_UNIT -- requirements
Module: bypass_hazard_unit

Interface
REQ-001 SHALL have parameter NUM_SRC, default 2: number of ID-stage source operands (1..4).
REQ-002 SHALL have parameter MD_LAT, default 4: multiply/divide latency in cycles (2..15).
REQ-003 SHALL have port clk, input, 1: single clock; reset is synchronous and active-high.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port id_valid, input, 1: an instruction is valid in ID.
REQ-006 SHALL have port id_src, input, NUM_SRC*5: source register numbers; slot k is bits [5k+4:5k].
REQ-007 SHALL have port id_src_used, input, NUM_SRC: slot k is actually read.
REQ-008 SHALL have port id_is_md, input, 1: the ID instruction is a multiply/divide.
REQ-009 SHALL have port id_md_dest, input, 5: destination of the ID multiply/divide.
REQ-010 SHALL have ports exe_rf_wen/mem_rf_wen/wb_rf_wen, input, 1 each: stage will write the register file (already qualified by stage valid).
REQ-011 SHALL have ports exe_wdest/mem_wdest/wb_wdest, input, 5 each: stage destination register.
REQ-012 SHALL have port exe_is_load, input, 1: the EXE instruction is a load.
REQ-013 SHALL have port fwd_sel, output, NUM_SRC*2: per slot 0=regfile, 1=EXE, 2=MEM, 3=WB.
REQ-014 SHALL have port id_stall, output, 1: hold ID and insert a bubble into EXE.
REQ-015 SHALL have port md_start, output, 1: multiply/divide issues this cycle.
REQ-016 SHALL have ports md_busy and md_done, output, 1 each: unit occupied; result commits at the end of this cycle.

Function
REQ-017 A slot SHALL match a stage only if id_src_used[k]=1, the stage's rf_wen=1, the stage's wdest equals id_src slot k, and wdest is not 0.
REQ-018 fwd_sel SHALL be combinational with priority EXE > MEM > WB, and 0 when no stage matches.
REQ-019 A load-use hazard (slot matches EXE and exe_is_load=1) SHALL assert id_stall; that slot's fwd_sel SHALL be 0.
REQ-020 The module SHALL hold one pending multiply/divide: a dest register plus a 4-bit down-counter cnt; md_busy = (cnt!=0); md_done = (cnt==1).
REQ-021 md_start SHALL equal id_valid & id_is_md & !id_stall.
REQ-022 On md_start at cycle T, cnt SHALL load MD_LAT and the dest SHALL be captured; md_busy is then high for cycles T+1..T+MD_LAT and md_done is high in cycle T+MD_LAT.
REQ-023 While cnt!=0 and md_start=0, cnt SHALL decrement each cycle.
REQ-024 A used, nonzero source equal to the pending dest while md_busy=1 SHALL assert id_stall, including in the md_done cycle, because the result is not forwarded.
REQ-025 id_is_md with md_busy=1 and md_done=0 SHALL assert id_stall. In the md_done cycle a new multiply/divide MAY start back-to-back, and the reload takes precedence over the decrement.
REQ-026 id_stall SHALL be the OR of all stall causes and SHALL be 0 when id_valid=0.
REQ-027 A pending dest of 0 SHALL occupy the unit but SHALL never cause a data stall.

Reset
REQ-028 With reset=1 at a clk edge, cnt and the pending dest SHALL be cleared, so md_busy=0, md_done=0 and md_start=0 when id_valid=0.
REQ-029 Reset during an in-flight multiply/divide SHALL abandon it with no md_done pulse.

Configuration
REQ-030 Macro BYPASS_WB_FWD_EN: when defined, WB matches SHALL forward with fwd_sel=3.
REQ-031 When BYPASS_WB_FWD_EN is not defined, a WB-only match SHALL assert id_stall for that cycle and fwd_sel SHALL never be 3.

Verification
REQ-032 id_src={r3,r2}, both used, exe_wdest=2, exe_rf_wen=1, mem_wdest=3, mem_rf_wen=1 -> fwd_sel={2,1}, id_stall=0.
REQ-033 exe_wdest=5, exe_is_load=1, slot0=r5 used -> id_stall=1, fwd_sel[1:0]=0, md_start=0.
REQ-034 MD_LAT=4, md issued at T with dest r8 -> md_busy for T+1..T+4, md_done at T+4, a dependent r8 reader stalls T+1..T+4 and proceeds at T+5.
REQ-035 Second md at T+2 -> stall; second md at T+4 -> md_start=1 and cnt reloads to 4; reset at T+2 -> md_busy=0 at T+3 and no md_done.
REQ-036 All stages writing r0 with r0 sources -> fwd_sel=0, id_stall=0; WB-only match on r7 -> fwd_sel=3 with the macro, id_stall=1 without it.

Source files
------------

// File: rtl/bypass_hazard_unit.sv
// ID-stage forwarding select, load-use / multiply-divide hazard stall and single-entry
// multiply/divide tracker. Define BYPASS_WB_FWD_EN to forward from WB instead of stalling.
module bypass_hazard_unit #(
   parameter int NUM_SRC = 2,
   parameter int MD_LAT  = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   id_valid,
   input  logic [NUM_SRC*5-1:0]   id_src,
   input  logic [NUM_SRC-1:0]     id_src_used,
   input  logic                   id_is_md,
   input  logic [4:0]             id_md_dest,
   input  logic                   exe_rf_wen,
   input  logic                   mem_rf_wen,
   input  logic                   wb_rf_wen,
   input  logic [4:0]             exe_wdest,
   input  logic [4:0]             mem_wdest,
   input  logic [4:0]             wb_wdest,
   input  logic                   exe_is_load,
   output logic [NUM_SRC*2-1:0]   fwd_sel,
   output logic                   id_stall,
   output logic                   md_start,
   output logic                   md_busy,
   output logic                   md_done
);

   logic [3:0]           md_cnt_r;
   logic [4:0]           md_dest_r;
   logic [NUM_SRC*2-1:0] fwd_sel_s;
   logic                 stall_any_s;
   logic [4:0]           src_s;

   assign md_busy = (md_cnt_r != 4'd0);
   assign md_done = (md_cnt_r == 4'd1);

   // Per-slot forwarding select (EXE > MEM > WB) and collection of all stall causes
   always_comb begin
      fwd_sel_s   = '0;
      stall_any_s = 1'b0;
      src_s       = 5'd0;
      for (int k = 0; k < NUM_SRC; k++) begin
         src_s = id_src[k*5 +: 5];
         // A nonzero source implies a nonzero matching wdest, so r0 never matches
         if (id_src_used[k] && (src_s != 5'd0)) begin
            if (exe_rf_wen && (exe_wdest == src_s)) begin
               if (exe_is_load) begin
                  stall_any_s = 1'b1;
               end else begin
                  fwd_sel_s[k*2 +: 2] = 2'd1;
               end
            end else if (mem_rf_wen && (mem_wdest == src_s)) begin
               fwd_sel_s[k*2 +: 2] = 2'd2;
            end else if (wb_rf_wen && (wb_wdest == src_s)) begin
`ifdef BYPASS_WB_FWD_EN
               fwd_sel_s[k*2 +: 2] = 2'd3;
`else
               stall_any_s = 1'b1;
`endif
            end else begin
               fwd_sel_s[k*2 +: 2] = 2'd0;
            end
            // The multiply/divide result is not forwarded, so readers wait through md_done
            stall_any_s = stall_any_s | (md_busy && (md_dest_r == src_s));
         end else begin
            fwd_sel_s[k*2 +: 2] = 2'd0;
         end
      end
      // Unit is free again in its md_done cycle, allowing back-to-back issue
      stall_any_s = stall_any_s | (id_is_md && md_busy && !md_done);
   end

   assign fwd_sel  = fwd_sel_s;
   assign id_stall = id_valid & stall_any_s;
   assign md_start = id_valid & id_is_md & ~id_stall;

   // Pending multiply/divide: reload on issue (wins over decrement), else count down to idle
   always_ff @(posedge clk) begin
      if (reset) begin
         md_cnt_r  <= 4'd0;
         md_dest_r <= 5'd0;
      end else if (md_start) begin
         md_cnt_r  <= 4'(MD_LAT);
         md_dest_r <= id_md_dest;
      end else if (md_busy) begin
         md_cnt_r  <= md_cnt_r - 4'd1;
      end else begin
         md_cnt_r  <= md_cnt_r;
      end
   end

endmodule

// File: tb/tb_bypass_hazard_unit.sv
// Self-checking bench for bypass_hazard_unit: vector table, multi-cycle md sequences and
// randomized stimulus against a cycle-time based reference model.
module tb_bypass_hazard_unit;
   localparam int NUM_SRC = 2;
   localparam int MD_LAT  = 4;

   logic       clk = 1'b0;
   logic       reset, id_valid, id_is_md, exe_rf_wen, mem_rf_wen, wb_rf_wen, exe_is_load;
   logic [9:0] id_src;
   logic [1:0] id_src_used;
   logic [4:0] id_md_dest, exe_wdest, mem_wdest, wb_wdest;
   logic [3:0] fwd_sel;
   logic       id_stall, md_start, md_busy, md_done;

   always #5 clk = ~clk;

   bypass_hazard_unit #(.NUM_SRC(NUM_SRC), .MD_LAT(MD_LAT)) dut (
      .clk(clk), .reset(reset), .id_valid(id_valid), .id_src(id_src),
      .id_src_used(id_src_used), .id_is_md(id_is_md), .id_md_dest(id_md_dest),
      .exe_rf_wen(exe_rf_wen), .mem_rf_wen(mem_rf_wen), .wb_rf_wen(wb_rf_wen),
      .exe_wdest(exe_wdest), .mem_wdest(mem_wdest), .wb_wdest(wb_wdest),
      .exe_is_load(exe_is_load), .fwd_sel(fwd_sel), .id_stall(id_stall),
      .md_start(md_start), .md_busy(md_busy), .md_done(md_done)
   );

   typedef struct {
      logic       vld;
      logic [9:0] src;
      logic [1:0] used;
      logic       is_md;
      logic [4:0] md_dest;
      logic       ew, mw, ww;
      logic [4:0] ed, md, wd;
      logic       eload;
   } in_t;

   typedef struct {
      in_t        in;
      logic [3:0] fwd;
      logic       stall;
      logic       start;
   } vec_t;

   int n_cmp  = 0;
   int n_fail = 0;

   // reference model state: time of the last issue rather than a counter
   bit         pend  = 1'b0;
   int         issue = 0;
   logic [4:0] pdest = 5'd0;
   int         cyc   = 0;

   logic [3:0] s_fwd;
   logic       s_stall, s_start, s_busy, s_done;
   vec_t       vq[$];

   task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   function automatic in_t idle();
      in_t x;
      x.vld = 1'b0; x.src = 10'd0; x.used = 2'b00; x.is_md = 1'b0; x.md_dest = 5'd0;
      x.ew = 1'b0; x.mw = 1'b0; x.ww = 1'b0; x.ed = 5'd0; x.md = 5'd0; x.wd = 5'd0;
      x.eload = 1'b0;
      return x;
   endfunction

   task automatic model(input in_t x, output logic [3:0] f, output logic st,
                        output logic go, output logic bz, output logic dn);
      logic       hz;
      logic [4:0] s;
      logic [4:0] wd [3];
      logic       we [3];
      int         first;
      bz = pend && (cyc > issue) && (cyc <= issue + MD_LAT);
      dn = pend && (cyc == issue + MD_LAT);
      wd = '{x.ed, x.md, x.wd};
      we = '{x.ew, x.mw, x.ww};
      f  = 4'd0;
      hz = 1'b0;
      for (int k = 0; k < NUM_SRC; k++) begin
         s = x.src[k*5 +: 5];
         if (x.used[k] && s != 5'd0) begin
            first = -1;
            for (int j = 2; j >= 0; j--) if (we[j] && wd[j] == s) first = j;
            if (first == 0 && x.eload) hz = 1'b1;
            else if (first == 2) begin
`ifdef BYPASS_WB_FWD_EN
               f[k*2 +: 2] = 2'd3;
`else
               hz = 1'b1;
`endif
            end
            else if (first >= 0) f[k*2 +: 2] = 2'(first + 1);
            if (bz && s == pdest) hz = 1'b1;
         end
      end
      if (x.is_md && bz && !dn) hz = 1'b1;
      st = x.vld && hz;
      go = x.vld && x.is_md && !st;
   endtask

   task automatic step(input in_t x, input logic rst, input bit en);
      logic [3:0] e_fwd;
      logic       e_st, e_go, e_bz, e_dn;
      id_valid = x.vld; id_src = x.src; id_src_used = x.used; id_is_md = x.is_md;
      id_md_dest = x.md_dest; exe_rf_wen = x.ew; mem_rf_wen = x.mw; wb_rf_wen = x.ww;
      exe_wdest = x.ed; mem_wdest = x.md; wb_wdest = x.wd; exe_is_load = x.eload;
      reset = rst;
      #2;
      model(x, e_fwd, e_st, e_go, e_bz, e_dn);
      s_fwd = fwd_sel; s_stall = id_stall; s_start = md_start;
      s_busy = md_busy; s_done = md_done;
      if (en) begin
         chk("fwd_sel", s_fwd, e_fwd);
         chk("id_stall", 4'(s_stall), 4'(e_st));
         chk("md_start", 4'(s_start), 4'(e_go));
         chk("md_busy", 4'(s_busy), 4'(e_bz));
         chk("md_done", 4'(s_done), 4'(e_dn));
      end
      @(posedge clk);
      if (rst) pend = 1'b0;
      else if (e_go) begin
         pend = 1'b1; issue = cyc; pdest = x.md_dest;
      end
      cyc++;
      #1;
   endtask

   task automatic add(input in_t x, input logic [3:0] f, input logic s, input logic g);
      vec_t v;
      v.in = x; v.fwd = f; v.stall = s; v.start = g;
      vq.push_back(v);
   endtask

   initial begin
      in_t x, r, m;

      // vector table (unit idle except the final issuing vector)
      x = idle(); x.vld = 1'b1; x.src = {5'd3, 5'd2}; x.used = 2'b11;
      x.ew = 1'b1; x.ed = 5'd2; x.mw = 1'b1; x.md = 5'd3;
      add(x, 4'b1001, 1'b0, 1'b0);
      x = idle(); x.vld = 1'b1; x.src = {5'd0, 5'd5}; x.used = 2'b01;
      x.ew = 1'b1; x.ed = 5'd5; x.eload = 1'b1;
      add(x, 4'b0000, 1'b1, 1'b0);
      x = idle(); x.vld = 1'b1; x.used = 2'b11; x.ew = 1'b1; x.mw = 1'b1; x.ww = 1'b1;
      add(x, 4'b0000, 1'b0, 1'b0);
      x = idle(); x.vld = 1'b1; x.src = {5'd0, 5'd7}; x.used = 2'b01;
      x.ww = 1'b1; x.wd = 5'd7;
`ifdef BYPASS_WB_FWD_EN
      add(x, 4'b0011, 1'b0, 1'b0);
`else
      add(x, 4'b0000, 1'b1, 1'b0);
`endif
      x = idle(); x.vld = 1'b1; x.src = {5'd0, 5'd4}; x.used = 2'b01;
      x.ew = 1'b1; x.ed = 5'd4; x.mw = 1'b1; x.md = 5'd4; x.ww = 1'b1; x.wd = 5'd4;
      add(x, 4'b0001, 1'b0, 1'b0);
      x = idle(); x.vld = 1'b1; x.src = {5'd6, 5'd1}; x.used = 2'b11;
      x.mw = 1'b1; x.md = 5'd6; x.ww = 1'b1; x.wd = 5'd6;
      add(x, 4'b1000, 1'b0, 1'b0);
      x = idle(); x.vld = 1'b1; x.src = {5'd2, 5'd2}; x.used = 2'b00;
      x.ew = 1'b1; x.ed = 5'd2;
      add(x, 4'b0000, 1'b0, 1'b0);
      x = idle(); x.src = {5'd0, 5'd5}; x.used = 2'b01;
      x.ew = 1'b1; x.ed = 5'd5; x.eload = 1'b1;
      add(x, 4'b0000, 1'b0, 1'b0);
      x = idle(); x.vld = 1'b1; x.src = {5'd9, 5'd3}; x.used = 2'b11;
      x.ed = 5'd3; x.mw = 1'b1; x.md = 5'd9;
      add(x, 4'b1000, 1'b0, 1'b0);
      x = idle(); x.vld = 1'b1; x.src = {5'd5, 5'd1}; x.used = 2'b11;
      x.mw = 1'b1; x.md = 5'd1; x.ew = 1'b1; x.ed = 5'd5; x.eload = 1'b1;
      add(x, 4'b0010, 1'b1, 1'b0);
      x = idle(); x.vld = 1'b1; x.is_md = 1'b1; x.md_dest = 5'd3;
      x.src = {5'd0, 5'd5}; x.used = 2'b01; x.ew = 1'b1; x.ed = 5'd5; x.eload = 1'b1;
      add(x, 4'b0000, 1'b1, 1'b0);
      x = idle(); x.vld = 1'b1; x.is_md = 1'b1; x.md_dest = 5'd12;
      add(x, 4'b0000, 1'b0, 1'b1);

      step(idle(), 1'b1, 1'b0);
      step(idle(), 1'b1, 1'b1);
      chk("reset_busy", 4'(s_busy), 4'd0);

      foreach (vq[i]) begin
         step(vq[i].in, 1'b0, 1'b1);
         chk("tbl_fwd", s_fwd, vq[i].fwd);
         chk("tbl_stall", 4'(s_stall), 4'(vq[i].stall));
         chk("tbl_start", 4'(s_start), 4'(vq[i].start));
      end
      step(idle(), 1'b1, 1'b1);

      // dependent reader of r8 stalls T+1..T+4 and proceeds at T+5
      m = idle(); m.vld = 1'b1; m.is_md = 1'b1; m.md_dest = 5'd8;
      r = idle(); r.vld = 1'b1; r.src = {5'd0, 5'd8}; r.used = 2'b01;
      step(m, 1'b0, 1'b1);
      chk("s34_start", 4'(s_start), 4'd1);
      for (int i = 1; i <= 4; i++) begin
         step(r, 1'b0, 1'b1);
         chk("s34_busy", 4'(s_busy), 4'd1);
         chk("s34_stall", 4'(s_stall), 4'd1);
         chk("s34_done", 4'(s_done), 4'(i == 4));
      end
      step(r, 1'b0, 1'b1);
      chk("s34_busy_end", 4'(s_busy), 4'd0);
      chk("s34_stall_end", 4'(s_stall), 4'd0);

      // second md at T+2 stalls, at T+4 issues back-to-back and reloads
      step(m, 1'b0, 1'b1);
      step(idle(), 1'b0, 1'b1);
      x = m; x.md_dest = 5'd9;
      step(x, 1'b0, 1'b1);
      chk("s35_stall", 4'(s_stall), 4'd1);
      chk("s35_nostart", 4'(s_start), 4'd0);
      step(idle(), 1'b0, 1'b1);
      step(x, 1'b0, 1'b1);
      chk("s35_b2b_start", 4'(s_start), 4'd1);
      chk("s35_b2b_done", 4'(s_done), 4'd1);
      step(idle(), 1'b0, 1'b1);
      chk("s35_reload_busy", 4'(s_busy), 4'd1);
      chk("s35_reload_done", 4'(s_done), 4'd0);
      step(idle(), 1'b0, 1'b1);
      step(idle(), 1'b0, 1'b1);
      step(idle(), 1'b0, 1'b1);
      chk("s35_reload_done4", 4'(s_done), 4'd1);
      step(idle(), 1'b0, 1'b1);
      chk("s35_idle", 4'(s_busy), 4'd0);

      // reset at T+2 abandons the operation without a done pulse
      step(m, 1'b0, 1'b1);
      step(idle(), 1'b0, 1'b1);
      step(idle(), 1'b1, 1'b1);
      chk("s35_rst_busy_pre", 4'(s_busy), 4'd1);
      for (int i = 0; i < 4; i++) begin
         step(idle(), 1'b0, 1'b1);
         chk("s35_rst_busy", 4'(s_busy), 4'd0);
         chk("s35_rst_done", 4'(s_done), 4'd0);
      end

      // dest r0 occupies the unit but never blocks a reader
      x = idle(); x.vld = 1'b1; x.is_md = 1'b1; x.md_dest = 5'd0;
      step(x, 1'b0, 1'b1);
      r = idle(); r.vld = 1'b1; r.used = 2'b11;
      step(r, 1'b0, 1'b1);
      chk("s27_nostall", 4'(s_stall), 4'd0);
      step(x, 1'b0, 1'b1);
      chk("s27_occupied", 4'(s_stall), 4'd1);

      for (int n = 0; n < 600; n++) begin
         x = idle();
         x.vld = ($urandom_range(0, 3) != 0);
         x.src = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
         x.used = 2'($urandom_range(0, 3));
         x.is_md = ($urandom_range(0, 3) == 0);
         x.md_dest = 5'($urandom_range(0, 7));
         x.ew = 1'($urandom_range(0, 1)); x.mw = 1'($urandom_range(0, 1));
         x.ww = 1'($urandom_range(0, 1));
         x.ed = 5'($urandom_range(0, 7)); x.md = 5'($urandom_range(0, 7));
         x.wd = 5'($urandom_range(0, 7));
         x.eload = 1'($urandom_range(0, 1));
         step(x, ($urandom_range(0, 59) == 0), 1'b1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
